// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master: FSM state encoding and the
// queued command format.
package apb_pkg;

    localparam int APB_A_WIDTH = 8;
    localparam int APB_D_WIDTH = 8;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                   write;
        logic [APB_A_WIDTH-1:0] addr;
        logic [APB_D_WIDTH-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// APB bus signals shared between one master and one slave.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int A_WIDTH = APB_A_WIDTH,
    parameter int D_WIDTH = APB_D_WIDTH
);

    logic               p_sel;
    logic               p_enable;
    logic               p_write;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic [D_WIDTH-1:0] rd_data;
    logic               p_ready;

    modport master (
        output p_sel, p_enable, p_write, p_addr, wr_data,
        input  rd_data, p_ready
    );

    modport slave (
        input  p_sel, p_enable, p_write, p_addr, wr_data,
        output rd_data, p_ready
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     p_clk,
    input  logic     p_rstn,
    input  logic     push,
    input  apb_cmd_t din,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output apb_cmd_t dout
);

    localparam int IW = $clog2(DEPTH);

    logic [IW:0] r_wptr;
    logic [IW:0] r_rptr;
    apb_cmd_t    r_mem [DEPTH];

    logic w_wr;
    logic w_rd;

    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
    assign dout  = r_mem[r_rptr[IW-1:0]];

    // NOTE: non-blocking assignments in every clocked block, so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after
    // it has been written, so resetting the pointers is sufficient.
    always_ff @(posedge p_clk) begin
        if (w_wr) r_mem[r_wptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_master.sv
// Command-stream to APB bridge: queues commands, runs IDLE/SETUP/ACCESS and
// returns one response per command, with a bounded p_ready wait.
module apb_master
    import apb_pkg::*;
#(
    parameter int A_WIDTH   = APB_A_WIDTH,
    parameter int D_WIDTH   = APB_D_WIDTH,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = APB_TIMEOUT
) (
    input  logic               p_clk,
    input  logic               p_rstn,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_wdata,

    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               busy,

    apb_master_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_p_sel;
    logic               r_p_enable;
    logic               r_p_write;
    logic [A_WIDTH-1:0] r_p_addr;
    logic [D_WIDTH-1:0] r_wr_data;
    logic               r_rsp_valid;
    logic [D_WIDTH-1:0] r_rsp_rdata;
    logic               r_rsp_err;

    apb_cmd_t w_din;
    apb_cmd_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_timeout;
    logic     w_complete;
    logic     w_pop;

    assign w_din = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    assign w_timeout  = !bus.p_ready && (r_cnt == CW'(TIMEOUT - 1));
    assign w_complete = (r_state == ACCESS) && (bus.p_ready || w_timeout);
    assign w_pop      = !w_empty && ((r_state == IDLE) || w_complete);

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .p_clk  (p_clk),
        .p_rstn (p_rstn),
        .push   (cmd_valid && cmd_ready),
        .din    (w_din),
        .pop    (w_pop),
        .full   (w_full),
        .empty  (w_empty),
        .dout   (w_head)
    );

    always_ff @(posedge p_clk or negedge p_rstn) begin
        if (!p_rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_p_sel     <= 1'b0;
            r_p_enable  <= 1'b0;
            r_p_write   <= 1'b0;
            r_p_addr    <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_p_addr  <= w_head.addr;
                        r_p_write <= w_head.write;
                        r_wr_data <= w_head.write ? w_head.wdata : '0;
                        r_p_sel   <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_p_enable <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= ACCESS;
                end
                ACCESS: begin
                    if (w_complete) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !bus.p_ready;
                        r_rsp_rdata <= (bus.p_ready && !r_p_write) ? bus.rd_data : '0;
                        r_p_enable  <= 1'b0;
                        // Chain straight into the next SETUP so p_sel never drops.
                        if (!w_empty) begin
                            r_p_addr  <= w_head.addr;
                            r_p_write <= w_head.write;
                            r_wr_data <= w_head.write ? w_head.wdata : '0;
                            r_state   <= SETUP;
                        end else begin
                            r_p_sel <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_p_sel    <= 1'b0;
                    r_p_enable <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = !w_full;
    assign busy      = (r_state != IDLE) || !w_empty;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign bus.p_sel    = r_p_sel;
    assign bus.p_enable = r_p_enable;
    assign bus.p_write  = r_p_write;
    assign bus.p_addr   = r_p_addr;
    assign bus.wr_data  = r_wr_data;

endmodule
